fir_stream_ctrl: RTL and testbench
==================================

FIR_STREAM_CTRL -- requirements
Module: fir_stream_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Parameters SHALL be, one per line as name, default, meaning:
  INPUT_WIDTH, 8, sample width (signed).
  RESULT_WIDTH, 18, filter result width (signed).
  FIFO_DEPTH, 4, sample FIFO entries (power of 2, >=2).
  TIMEOUT, 16, maximum cycles to wait in any filter-wait state.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  clock.
  rst  in  1  synchronous active-high reset.
  s_data  in  INPUT_WIDTH  upstream sample.
  s_valid  in  1  upstream sample valid.
  s_ready  out  1  FIFO can accept.
  fir_data  out  INPUT_WIDTH  sample to filter.
  fir_flag  out  1  one-cycle new-sample strobe to filter.
  fir_done  in  1  filter idle/result-valid level.
  fir_result  in  RESULT_WIDTH  filter accumulated result.
  m_data  out  RESULT_WIDTH  captured result.
  m_valid  out  1  result valid.
  m_ready  in  1  downstream accepts.
  busy  out  1  high in any state except IDLE.
  timeout_err  out  1  sticky filter-timeout flag.

Function
REQ-004 Upstream transfer SHALL occur when s_valid and s_ready are both high on a clk edge; the sample SHALL be written to the FIFO tail.
REQ-005 s_ready SHALL equal NOT full and SHALL be registered state only (no combinational path from m_ready, fir_done or s_valid).
REQ-006 A push and a pop on the same edge SHALL both take effect, leaving occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-007 FSM states SHALL be IDLE, ISSUE, WAIT_LOW, WAIT_DONE, HOLD.
REQ-008 IDLE -> ISSUE when FIFO not empty, fir_done = 1 and m_valid = 0 (or m_valid = 1 with m_ready = 1 on that edge).
REQ-009 In ISSUE (exactly one cycle) fir_flag SHALL be 1, fir_data SHALL equal the FIFO head, the head SHALL be popped, next state WAIT_LOW.
REQ-010 fir_flag SHALL be 0 in every state other than ISSUE; fir_data SHALL hold its last issued value outside ISSUE.
REQ-011 WAIT_LOW -> WAIT_DONE when fir_done = 0.
REQ-012 WAIT_DONE -> HOLD when fir_done = 1; on that edge m_data SHALL load fir_result and m_valid SHALL be set to 1.
REQ-013 HOLD -> IDLE when m_valid = 1 and m_ready = 1; m_valid SHALL clear on that edge.
REQ-014 m_data SHALL remain stable while m_valid = 1 and m_ready = 0.
REQ-015 A wait counter SHALL reset on entry to WAIT_LOW and WAIT_DONE and increment each cycle in those states; on reaching TIMEOUT the FSM SHALL go to IDLE, set timeout_err, discard the issued sample, and leave m_valid = 0.
REQ-016 timeout_err SHALL clear only on rst.
REQ-017 fir_result SHALL be captured bit-exact, with no sign extension, truncation or rounding.
REQ-018 Throughput SHALL be at most one filter operation in flight; no new fir_flag SHALL be issued before the previous result is accepted downstream.

Reset
REQ-019 On rst = 1 at a clk edge: FSM = IDLE, FIFO empty (s_ready = 1 on the next cycle), fir_flag = 0, fir_data = 0, m_data = 0, m_valid = 0, busy = 0, timeout_err = 0, wait counter = 0.
REQ-020 rst asserted mid-operation SHALL abandon the in-flight sample and all FIFO contents, with no m_valid produced for them.

Verification
REQ-021 Single sample: reset, push 5. The responder drops fir_done 1 cycle after fir_flag, raises it 5 cycles later with fir_result = 18'h00123. Required: exactly one fir_flag pulse with fir_data = 5, then m_valid = 1 with m_data = 18'h00123.
REQ-022 FIFO full: hold fir_done = 0 before the first issue and push 6 samples. Required: s_ready = 0 after 4 accepted samples; samples 5 and 6 stall until space frees; no sample is lost.
REQ-023 Backpressure: m_ready = 0 for 10 cycles with 3 samples queued. Required: m_data is stable, no further fir_flag is issued, and results come out in order after m_ready = 1.
REQ-024 Timeout: the responder never drops fir_done. Required: after 16 cycles in WAIT_LOW, timeout_err = 1, FSM returns to IDLE, m_valid stays 0, and the next sample issues.
REQ-025 Signed extremes: push -128 and 127; the responder returns 18'h20000 and 18'h1FFFF. Required: m_data matches bit-exactly.
REQ-026 Mid-operation reset: assert rst during WAIT_DONE with 2 samples queued. Required: all REQ-019 values on the next cycle, and no m_valid for the abandoned samples.

Source files
------------

// File: rtl/fir_stream_ctrl_if.sv
// Handshake bundle for fir_stream_ctrl: upstream samples, filter strobe/result, downstream results.
// master is the controller side, slave is the surrounding environment.
interface fir_stream_ctrl_if #(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned RESULT_WIDTH = 18
);
    logic [INPUT_WIDTH-1:0]  s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic [INPUT_WIDTH-1:0]  fir_data;
    logic                    fir_flag;
    logic                    fir_done;
    logic [RESULT_WIDTH-1:0] fir_result;
    logic [RESULT_WIDTH-1:0] m_data;
    logic                    m_valid;
    logic                    m_ready;

    modport master (
        input  s_data, s_valid, fir_done, fir_result, m_ready,
        output s_ready, fir_data, fir_flag, m_data, m_valid
    );

    modport slave (
        output s_data, s_valid, fir_done, fir_result, m_ready,
        input  s_ready, fir_data, fir_flag, m_data, m_valid
    );
endinterface

// File: rtl/fir_stream_ctrl.sv
// Sample FIFO feeding an external FIR engine one sample at a time, with result hold,
// downstream handshake and a sticky timeout flag for an unresponsive filter.
module fir_stream_ctrl #(
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned RESULT_WIDTH = 18,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic                clk,
    input  logic                rst,
    fir_stream_ctrl_if.master   bus,
    output logic                busy,
    output logic                timeout_err
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_DONE, HOLD} state_t;

    state_t                 state;
    logic [INPUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic [WAIT_W-1:0]      wait_cnt;
    logic                   push;
    logic                   pop;
    logic                   wait_expired;

    // The head is popped on the ISSUE cycle, after fir_data has already latched it.
    assign push         = bus.s_valid && bus.s_ready;
    assign pop          = (state == ISSUE);
    assign count_next   = count + CNT_W'(push) - CNT_W'(pop);
    assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.s_ready  <= 1'b1;
            bus.fir_flag <= 1'b0;
            bus.fir_data <= '0;
            bus.m_data   <= '0;
            bus.m_valid  <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count        <= count_next;
            bus.s_ready  <= (count_next != CNT_W'(FIFO_DEPTH));
            bus.fir_flag <= 1'b0;

            case (state)
                IDLE: begin
                    if ((count != '0) && bus.fir_done && (!bus.m_valid || bus.m_ready)) begin
                        state        <= ISSUE;
                        bus.fir_flag <= 1'b1;
                        bus.fir_data <= mem[rd_ptr];
                        bus.m_valid  <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT_LOW;
                    wait_cnt <= '0;
                end
                WAIT_LOW: begin
                    if (!bus.fir_done) begin
                        state    <= WAIT_DONE;
                        wait_cnt <= '0;
                    end else if (wait_expired) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (bus.fir_done) begin
                        state       <= HOLD;
                        bus.m_data  <= bus.fir_result;
                        bus.m_valid <= 1'b1;
                    end else if (wait_expired) begin
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                HOLD: begin
                    if (bus.m_valid && bus.m_ready) begin
                        state       <= IDLE;
                        bus.m_valid <= 1'b0;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl with a behavioural filter responder and result monitor.
module tb_fir_stream_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic timeout_err;

    fir_stream_ctrl_if #(.INPUT_WIDTH(8), .RESULT_WIDTH(18)) bus ();

    fir_stream_ctrl #(
        .INPUT_WIDTH(8), .RESULT_WIDTH(18), .FIFO_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int resp_mode = 0;  // 0 normal, 1 never drops fir_done, 2 holds fir_done low
    int resp_cnt = 0;
    logic [7:0] resp_sample = 8'h00;
    int flag_cnt = 0;
    int stab_viol = 0;
    int overlap_viol = 0;
    logic [7:0] issued[$];
    logic [17:0] results[$];
    logic prev_mv = 1'b0;
    logic prev_mr = 1'b0;
    logic [17:0] prev_md = 18'h0;

    function automatic logic [17:0] resp_fn(input logic [7:0] s);
        case (s)
            8'h05:   return 18'h00123;
            8'h80:   return 18'h20000;
            8'h7F:   return 18'h1FFFF;
            default: return {10'h155, s};
        endcase
    endfunction

    // Filter model: drops fir_done the cycle after the strobe, raises it 5 cycles later.
    always @(negedge clk) begin
        if (rst === 1'b1 || resp_mode != 0) begin
            resp_cnt = 0;
            bus.fir_done = (resp_mode == 2) ? 1'b0 : 1'b1;
        end else if (bus.fir_flag) begin
            resp_sample = bus.fir_data;
            resp_cnt = 1;
        end else if (resp_cnt == 1) begin
            bus.fir_done = 1'b0;
            resp_cnt = 2;
        end else if (resp_cnt >= 2 && resp_cnt < 6) begin
            resp_cnt++;
        end else if (resp_cnt == 6) begin
            bus.fir_result = resp_fn(resp_sample);
            bus.fir_done = 1'b1;
            resp_cnt = 0;
        end else begin
            bus.fir_done = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.fir_flag === 1'b1) begin
                flag_cnt++;
                issued.push_back(bus.fir_data);
                if (bus.m_valid === 1'b1) overlap_viol++;
            end
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) results.push_back(bus.m_data);
            if (prev_mv && !prev_mr && bus.m_valid === 1'b1 && bus.m_data !== prev_md) stab_viol++;
        end
        prev_mv = bus.m_valid;
        prev_mr = bus.m_ready;
        prev_md = bus.m_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"},     32'(bus.s_ready),   32'd1);
        check({tag, "_fir_flag"},    32'(bus.fir_flag),  32'd0);
        check({tag, "_fir_data"},    32'(bus.fir_data),  32'd0);
        check({tag, "_m_data"},      32'(bus.m_data),    32'd0);
        check({tag, "_m_valid"},     32'(bus.m_valid),   32'd0);
        check({tag, "_busy"},        32'(busy),          32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err),   32'd0);
    endtask

    task automatic push(input logic [7:0] d, input int budget);
        logic acc;
        int n;
        n = 0;
        bus.s_data = d;
        bus.s_valid = 1'b1;
        do begin
            acc = bus.s_ready;
            tick();
            n++;
        end while (!acc && n < budget);
        bus.s_valid = 1'b0;
        check("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic wait_results(input int cnt, input int budget, input string tag);
        int k;
        k = 0;
        while (results.size() < cnt && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(results.size()), 32'(cnt));
    endtask

    task automatic wait_mvalid(input int budget, input string tag);
        int k;
        k = 0;
        while (bus.m_valid !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(bus.m_valid), 32'd1);
    endtask

    function automatic logic [31:0] res_at(input int i);
        return (i < results.size()) ? 32'(results[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] iss_at(input int i);
        return (i < issued.size()) ? 32'(issued[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        int f0;
        int n;
        logic [17:0] md0;

        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        bus.m_ready = 1'b1;
        repeat (3) tick();
        check_reset("rst");
        rst = 1'b0;
        tick();

        // Single sample
        bus.m_ready = 1'b0;
        issued.delete();
        results.delete();
        f0 = flag_cnt;
        push(8'd5, 4);
        wait_mvalid(40, "t1_mvalid");
        check("t1_mdata", 32'(bus.m_data), 32'h00123);
        check("t1_flags", 32'(flag_cnt - f0), 32'd1);
        check("t1_fir_data", iss_at(0), 32'd5);
        check("t1_busy", 32'(busy), 32'd1);
        bus.m_ready = 1'b1;
        tick();
        check("t1_mvalid_clr", 32'(bus.m_valid), 32'd0);
        check("t1_busy_clr", 32'(busy), 32'd0);
        check("t1_fir_data_hold", 32'(bus.fir_data), 32'd5);

        // FIFO full with the filter held busy
        results.delete();
        issued.delete();
        resp_mode = 2;
        tick();
        f0 = flag_cnt;
        for (int i = 1; i <= 4; i++) push(8'(i), 4);
        check("t2_full", 32'(bus.s_ready), 32'd0);
        check("t2_no_issue", 32'(flag_cnt - f0), 32'd0);
        bus.s_data = 8'd5;
        bus.s_valid = 1'b1;
        repeat (3) tick();
        check("t2_stall", 32'(bus.s_ready), 32'd0);
        bus.s_valid = 1'b0;
        resp_mode = 0;
        push(8'd5, 60);
        push(8'd6, 60);
        wait_results(6, 200, "t2_count");
        for (int i = 0; i < 6; i++) check("t2_order", res_at(i), 32'(resp_fn(8'(i + 1))));

        // Downstream backpressure
        results.delete();
        bus.m_ready = 1'b0;
        push(8'd10, 4);
        push(8'd11, 4);
        push(8'd12, 4);
        wait_mvalid(40, "t3_mvalid");
        md0 = bus.m_data;
        f0 = flag_cnt;
        repeat (10) tick();
        check("t3_mdata", 32'(bus.m_data), 32'(resp_fn(8'd10)));
        check("t3_stable", 32'(bus.m_data), 32'(md0));
        check("t3_no_issue", 32'(flag_cnt - f0), 32'd0);
        check("t3_mvalid_held", 32'(bus.m_valid), 32'd1);
        bus.m_ready = 1'b1;
        wait_results(3, 100, "t3_count");
        for (int i = 0; i < 3; i++) check("t3_order", res_at(i), 32'(resp_fn(8'(10 + i))));

        // Filter never responds
        results.delete();
        resp_mode = 1;
        tick();
        push(8'd20, 4);
        n = 0;
        while (bus.fir_flag !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("t4_issue", 32'(bus.fir_flag), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (timeout_err !== 1'b1 && n < 40);
        check("t4_cycles", 32'(n), 32'd17);
        check("t4_timeout_err", 32'(timeout_err), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);
        check("t4_mvalid", 32'(bus.m_valid), 32'd0);
        check("t4_no_result", 32'(results.size()), 32'd0);
        resp_mode = 0;
        push(8'd21, 4);
        wait_results(1, 40, "t4_next");
        check("t4_next_data", res_at(0), 32'(resp_fn(8'd21)));
        check("t4_sticky", 32'(timeout_err), 32'd1);

        // Signed extremes
        results.delete();
        issued.delete();
        push(8'h80, 4);
        push(8'h7F, 20);
        wait_results(2, 100, "t5_count");
        check("t5_min", res_at(0), 32'h20000);
        check("t5_max", res_at(1), 32'h1FFFF);
        check("t5_fir_min", iss_at(0), 32'h80);
        check("t5_fir_max", iss_at(1), 32'h7F);

        // Reset while waiting for the filter, with samples queued
        results.delete();
        push(8'd30, 4);
        push(8'd31, 4);
        push(8'd32, 4);
        n = 0;
        while (bus.fir_done !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("t6_in_wait", 32'(bus.fir_done), 32'd0);
        f0 = flag_cnt;
        rst = 1'b1;
        tick();
        check_reset("t6_rst");
        rst = 1'b0;
        repeat (20) tick();
        check("t6_no_result", 32'(results.size()), 32'd0);
        check("t6_no_issue", 32'(flag_cnt - f0), 32'd0);
        check("t6_idle", 32'(busy), 32'd0);

        check("stable_viol", 32'(stab_viol), 32'd0);
        check("overlap_viol", 32'(overlap_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
